// File: rtl/cpu_types_pkg.sv
// Shared CPU/bus type definitions used by the bus FSM and the bus request arbiter.
package cpu_types_pkg;

  // Transaction class of a bus grant; ARB_NONE means no grant is held.
  typedef enum logic [1:0] {
    ARB_NONE   = 2'd0,
    ARB_WB     = 2'd1,
    ARB_DATA   = 2'd2,
    ARB_IFETCH = 2'd3
  } arb_class_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick #(
  parameter int CPUS = 2,
  parameter int ID_W = 1
) (
  input  logic [CPUS-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic            found,
  output logic [ID_W-1:0] idx
);

  // The second loop overrides the first, so a requester at or above ptr beats a
  // wrapped one; each loop runs downward so the lowest index of its range wins.
  always_comb begin
    // NOTE: every output gets a default before the loops so no path leaves it
    // unassigned, which would otherwise infer a latch.
    found = 1'b0;
    idx   = '0;
    for (int j = CPUS - 1; j >= 0; j--) begin
      if (req[j] && (j < int'(ptr))) begin
        found = 1'b1;
        idx   = ID_W'(j);
      end
    end
    for (int j = CPUS - 1; j >= 0; j--) begin
      if (req[j] && (j >= int'(ptr))) begin
        found = 1'b1;
        idx   = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/bus_request_arbiter.sv
// Round-robin bus arbiter: grants one core/class, holds it until done, abort or watchdog.
module bus_request_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS    = 2,
  parameter int TIMEOUT = 255,
  localparam int ID_W   = (CPUS > 1) ? $clog2(CPUS) : 1
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [CPUS-1:0] wbreq,
  input  logic [CPUS-1:0] dreq,
  input  logic [CPUS-1:0] ireq,
  input  logic            done,
  output logic            grant_valid,
  output logic [ID_W-1:0] grant_id,
  output arb_class_t      grant_class,
  output logic            timeout,
  output logic            abort
);

  typedef enum logic {IDLE, OWN} state_t;

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

  state_t          state;
  logic [ID_W-1:0] ptr;
  logic [7:0]      count;

  logic            wb_found, d_found, i_found;
  logic [ID_W-1:0] wb_idx, d_idx, i_idx;
  arb_class_t      win_class;
  logic [ID_W-1:0] win_id;
  logic            owner_req;
  logic [ID_W-1:0] next_ptr;

  rr_pick #(.CPUS(CPUS), .ID_W(ID_W)) u_pick_wb (
    .req(wbreq), .ptr(ptr), .found(wb_found), .idx(wb_idx)
  );
  rr_pick #(.CPUS(CPUS), .ID_W(ID_W)) u_pick_data (
    .req(dreq), .ptr(ptr), .found(d_found), .idx(d_idx)
  );
  rr_pick #(.CPUS(CPUS), .ID_W(ID_W)) u_pick_ifetch (
    .req(ireq), .ptr(ptr), .found(i_found), .idx(i_idx)
  );

  // Class priority is global: any write-back beats any data request, and so on.
  always_comb begin
    win_class = ARB_NONE;
    win_id    = '0;
    if (wb_found) begin
      win_class = ARB_WB;
      win_id    = wb_idx;
    end else if (d_found) begin
      win_class = ARB_DATA;
      win_id    = d_idx;
    end else if (i_found) begin
      win_class = ARB_IFETCH;
      win_id    = i_idx;
    end
  end

  always_comb begin
    owner_req = 1'b0;
    case (grant_class)
      ARB_WB:     owner_req = wbreq[grant_id];
      ARB_DATA:   owner_req = dreq[grant_id];
      ARB_IFETCH: owner_req = ireq[grant_id];
      default:    owner_req = 1'b0;
    endcase
  end

  assign next_ptr = (grant_id == ID_W'(CPUS - 1)) ? '0 : grant_id + 1'b1;

  // NOTE: all state here is sequential, so it is written with non-blocking
  // assignments; every register reads its pre-edge value within the block.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      ptr         <= '0;
      count       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      grant_class <= ARB_NONE;
      timeout     <= 1'b0;
      abort       <= 1'b0;
    end else begin
      timeout <= 1'b0;
      abort   <= 1'b0;
      case (state)
        IDLE: begin
          if (win_class != ARB_NONE) begin
            state       <= OWN;
            grant_valid <= 1'b1;
            grant_id    <= win_id;
            grant_class <= win_class;
            count       <= '0;
          end
        end
        OWN: begin
          if (count != 8'hFF) count <= count + 8'd1;
          // done outranks abort, which outranks the watchdog.
          if (done || !owner_req || (count == LAST_COUNT)) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_class <= ARB_NONE;
            ptr         <= next_ptr;
            if (!done) begin
              if (!owner_req) abort   <= 1'b1;
              else            timeout <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_request_arbiter.sv
// Self-checking bench for bus_request_arbiter: directed stimulus, ownership model, per-cycle compare.
module tb_bus_request_arbiter;
  import cpu_types_pkg::*;

  localparam int CPUS    = 2;
  localparam int TIMEOUT = 8;

  logic            CLK = 1'b0;
  logic            nRST;
  logic [CPUS-1:0] wbreq = '0;
  logic [CPUS-1:0] dreq  = '0;
  logic [CPUS-1:0] ireq  = '0;
  logic            done  = 1'b0;
  logic            grant_valid;
  logic [0:0]      grant_id;
  arb_class_t      grant_class;
  logic            timeout;
  logic            abort;

  int n_vec = 0;
  int n_err = 0;

  bus_request_arbiter #(.CPUS(CPUS), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .nRST(nRST), .wbreq(wbreq), .dreq(dreq), .ireq(ireq), .done(done),
    .grant_valid(grant_valid), .grant_id(grant_id), .grant_class(grant_class),
    .timeout(timeout), .abort(abort)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- ownership model ----------------
  // Owner is -1 when the bus is free; age counts completed cycles of ownership.
  int         m_owner = -1;
  arb_class_t m_class = ARB_NONE;
  int         m_ptr   = 0;
  int         m_age   = 0;
  bit         m_to    = 1'b0;
  bit         m_ab    = 1'b0;

  function automatic int pick(input logic [CPUS-1:0] v, input int from);
    for (int j = 0; j < CPUS; j++)
      if (v[(from + j) % CPUS]) return (from + j) % CPUS;
    return -1;
  endfunction

  function automatic bit still_requesting(input int who, input arb_class_t cls);
    case (cls)
      ARB_WB:     return wbreq[who];
      ARB_DATA:   return dreq[who];
      ARB_IFETCH: return ireq[who];
      default:    return 1'b0;
    endcase
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_owner = -1; m_class = ARB_NONE; m_ptr = 0; m_age = 0; m_to = 0; m_ab = 0;
    end else begin
      m_to = 0;
      m_ab = 0;
      if (m_owner < 0) begin
        if (pick(wbreq, m_ptr) >= 0) begin
          m_owner = pick(wbreq, m_ptr); m_class = ARB_WB;
        end else if (pick(dreq, m_ptr) >= 0) begin
          m_owner = pick(dreq, m_ptr); m_class = ARB_DATA;
        end else if (pick(ireq, m_ptr) >= 0) begin
          m_owner = pick(ireq, m_ptr); m_class = ARB_IFETCH;
        end
        m_age = 0;
      end else begin
        m_age++;
        if (done || !still_requesting(m_owner, m_class) || m_age == TIMEOUT) begin
          if (!done) begin
            if (!still_requesting(m_owner, m_class)) m_ab = 1;
            else                                     m_to = 1;
          end
          m_ptr   = (m_owner + 1) % CPUS;
          m_owner = -1;
          m_class = ARB_NONE;
        end
      end
    end
  end

  // Every falling edge, outputs are compared with the model.
  always @(negedge CLK) begin
    check("model grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
    check("model timeout", 32'(timeout), 32'(m_to));
    check("model abort", 32'(abort), 32'(m_ab));
    if (m_owner >= 0) begin
      check("model grant_id", 32'(grant_id), m_owner);
      check("model grant_class", 32'(grant_class), 32'(m_class));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic expect_grant(input string name, input int id, input arb_class_t cls);
    check({name, " valid"}, 32'(grant_valid), 32'd1);
    check({name, " id"}, 32'(grant_id), id);
    check({name, " class"}, 32'(grant_class), 32'(cls));
  endtask

  initial begin
    int n;
    nRST = 1'b0;
    tick(); tick();
    check("reset grant_valid", 32'(grant_valid), 32'd0);
    check("reset grant_id", 32'(grant_id), 32'd0);
    check("reset grant_class", 32'(grant_class), 32'(ARB_NONE));
    check("reset timeout", 32'(timeout), 32'd0);
    check("reset abort", 32'(abort), 32'd0);
    nRST = 1'b1;
    tick();

    // Single ifetch request from core 1, then done.
    ireq = 2'b10;
    tick();
    expect_grant("single", 1, ARB_IFETCH);
    done = 1'b1;
    tick();
    check("single release", 32'(grant_valid), 32'd0);
    done = 1'b0; ireq = 2'b00;
    tick();

    // Class priority: WB core 0 first, then DATA core 1.
    wbreq = 2'b01; dreq = 2'b10; ireq = 2'b11;
    tick();
    expect_grant("prio wb", 0, ARB_WB);
    done = 1'b1; wbreq = 2'b00;
    tick();
    check("prio gap", 32'(grant_valid), 32'd0);
    done = 1'b0;
    tick();
    expect_grant("prio data", 1, ARB_DATA);
    done = 1'b1;
    tick();
    done = 1'b0; dreq = 2'b00; ireq = 2'b00;
    tick();

    // Round robin with both cores requesting data.
    dreq = 2'b11;
    for (int g = 0; g < 4; g++) begin
      tick();
      expect_grant("rr", g % 2, ARB_DATA);
      tick(); tick();
      done = 1'b1;
      tick();
      check("rr idle gap", 32'(grant_valid), 32'd0);
      done = 1'b0;
    end
    dreq = 2'b00;
    tick();

    // Watchdog: ownership lasts exactly TIMEOUT cycles, then ptr moves on.
    dreq = 2'b11;
    tick();
    expect_grant("wdog", 0, ARB_DATA);
    n = 0;
    while (grant_valid && n < 20) begin
      tick();
      n++;
    end
    check("wdog cycles", n, 32'd8);
    check("wdog pulse", 32'(timeout), 32'd1);
    tick();
    expect_grant("wdog rotate", 1, ARB_DATA);
    check("wdog pulse end", 32'(timeout), 32'd0);
    done = 1'b1;
    tick();
    done = 1'b0; dreq = 2'b00;
    tick();

    // Abort: owner drops its request.
    dreq = 2'b01;
    tick();
    expect_grant("abort", 0, ARB_DATA);
    dreq = 2'b00;
    tick();
    check("abort release", 32'(grant_valid), 32'd0);
    check("abort pulse", 32'(abort), 32'd1);
    tick();
    check("abort pulse end", 32'(abort), 32'd0);

    // done and request drop at the same edge: no abort.
    dreq = 2'b10;
    tick();
    expect_grant("done+drop", 1, ARB_DATA);
    dreq = 2'b00; done = 1'b1;
    tick();
    check("done+drop abort", 32'(abort), 32'd0);
    check("done+drop valid", 32'(grant_valid), 32'd0);
    done = 1'b0;
    tick();

    // done coincides with watchdog expiry: no timeout.
    dreq = 2'b01;
    tick();
    expect_grant("done+wdog", 0, ARB_DATA);
    repeat (7) tick();
    check("done+wdog held", 32'(grant_valid), 32'd1);
    done = 1'b1;
    tick();
    check("done+wdog timeout", 32'(timeout), 32'd0);
    check("done+wdog valid", 32'(grant_valid), 32'd0);
    done = 1'b0; dreq = 2'b00;
    tick();

    // Abort coincides with watchdog expiry: abort wins.
    dreq = 2'b10;
    tick();
    expect_grant("abort+wdog", 1, ARB_DATA);
    repeat (7) tick();
    dreq = 2'b00;
    tick();
    check("abort+wdog abort", 32'(abort), 32'd1);
    check("abort+wdog timeout", 32'(timeout), 32'd0);
    tick();

    // Asynchronous reset mid-ownership with ptr pointing at core 1.
    dreq = 2'b01;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0; dreq = 2'b11;
    tick();
    expect_grant("pre-reset", 1, ARB_DATA);
    #2 nRST = 1'b0;
    #1 check("async reset valid", 32'(grant_valid), 32'd0);
    check("async reset class", 32'(grant_class), 32'(ARB_NONE));
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    tick();
    expect_grant("post-reset", 0, ARB_DATA);
    dreq = 2'b00; done = 1'b1;
    tick();
    done = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global time limit: simulation did not finish");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/bus_request_arbiter.md
# bus_request_arbiter

Round-robin arbiter and transaction sequencer for the shared coherence bus and RAM port of the dual-core system. Each cycle it collects write-back, data (BusRd/BusRdX) and instruction-fetch requests from all cores, grants exactly one owner, and holds that grant until the bus FSM signals completion. A watchdog releases the grant if completion does not arrive. It sits in front of the memory/coherence controller, replacing that controller's ad-hoc grant bit.

## Interface
- CPUS, 2: number of requesting cores (at least 1).
- TIMEOUT, 255: maximum number of cycles in OWN before a forced release (1 to 255).
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- wbreq  in  CPUS  per-core write-back request (dWEN).
- dreq  in  CPUS  per-core coherent data request (dREN && cctrans).
- ireq  in  CPUS  per-core instruction-fetch request (iREN).
- done  in  1  one-cycle pulse from the bus FSM when the current transaction completes.
- grant_valid  out  1  a grant is held.
- grant_id  out  $clog2(CPUS) (minimum 1)  index of the owning core.
- grant_class  out  arb_class_t  class of the granted transaction.
- timeout  out  1  one-cycle pulse on a forced release.
- abort  out  1  one-cycle pulse when the owner drops its request before done.

## Operation
- **State machine:** two states, IDLE and OWN.
- **IDLE:**
  - Class priority is WB > DATA > IFETCH, applied globally across cores.
  - Within the winning class, the winner is the first requesting core at or after `ptr`, searching upward with wrap-around.
  - If any request is asserted: register the winner id and class, clear the watchdog, go to OWN.
  - `done` is ignored in IDLE.
- **OWN:**
  - grant_valid=1; grant_id and grant_class stay stable.
  - The watchdog counter increments every cycle.
  - `done` high: go to IDLE, set ptr to (grant_id+1) mod CPUS.
  - Otherwise, the owner's request of the granted class low: assert abort, go to IDLE, rotate ptr the same way.
  - Otherwise, counter reaches TIMEOUT-1: assert timeout, go to IDLE, rotate ptr.
  - Requests from non-owners and requests of other classes are ignored while in OWN.
- **Width rules:**
  - The counter is 8 bits and saturates; it cannot wrap while in OWN.
  - ptr wraps from CPUS-1 to 0.
  - With CPUS=1, ptr stays 0.

## Timing
- **Reset values:** grant_valid=0, grant_id=0, grant_class=ARB_NONE, timeout=0, abort=0, ptr=0, counter=0, state IDLE.
- **Grant latency:** a request sampled in IDLE at edge k produces grant_valid high after edge k, i.e. in cycle k+1. All outputs are registered.
- **Release:** `done` sampled at edge n drops grant_valid after edge n. At least one IDLE cycle separates consecutive grants, so back-to-back grants to different cores are 1 cycle apart.
- **Pulses:** timeout and abort are high for exactly the cycle after the releasing edge, coincident with the first IDLE cycle.
- **Simultaneous events at the same edge:**
  - done with abort condition: done wins, no abort.
  - done with timeout: done wins, no timeout.
  - abort with timeout: abort wins.
- **Reset mid-OWN:** all outputs take reset values immediately (asynchronous), and in-flight ownership is lost. The bus FSM must also reset.
- **Grant holding:** once granted, grant_class does not change even if a higher-priority class request appears mid-transaction.

## Structure
- Add `arb_class_t` (2-bit enum: ARB_NONE, ARB_WB, ARB_DATA, ARB_IFETCH) to cpu_types_pkg; the bus FSM and this block share it.
- `TIMEOUT` stays a local parameter of the block, not a package constant.
- One sub-module, `rr_pick`: combinational; takes a CPUS-bit request vector and ptr; outputs a found flag and the index.
  - Instantiated three times, once per class.
  - The class priority mux sits in the parent.

## Test plan
- **Reset and single request:** reset, then ireq=2'b10 → grant_valid=1, grant_id=1, class ARB_IFETCH in cycle 1; done pulse → grant_valid=0 next cycle, ptr=0.
- **Class priority:** wbreq=2'b01, dreq=2'b10 and ireq=2'b11 together → grant core 0 ARB_WB; after done, next grant is core 1 ARB_DATA.
- **Round-robin fairness:** dreq=2'b11 held with done every 4 cycles → grant_id alternates 0,1,0,1; one IDLE cycle between grants.
- **Watchdog:** TIMEOUT=8, grant held with no done → timeout pulse and release exactly 8 cycles after grant, ptr rotated.
- **Abort and simultaneous events:** owner drops dreq in OWN → abort pulse next cycle. done and request drop at the same edge → no abort.
- **Async reset mid-OWN:** nRST low mid-grant → grant_valid=0 without waiting for a clock edge; after release, first grant goes to core 0.
